// File: rtl/ring_pkg.sv
// Shared types and helpers for the privilege-ring controller.
//   ring_state_t  : controller states (KERNEL, USER, ENTRY, FAULT)
//   fault_cause_t : fault cause encoding reported on io_faultCause
//   is_below/is_above : 32-bit unsigned compares against parameter limits.
//     Routing the compares through a function keeps limits such as 0 or
//     2^ADDR_W-1 from turning into constant-false expressions at the call site.
package ring_pkg;

  typedef enum logic [1:0] {
    KERNEL = 2'd0,
    USER   = 2'd1,
    ENTRY  = 2'd2,
    FAULT  = 2'd3
  } ring_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_JUMP  = 3'd1,
    CAUSE_WRITE = 3'd2,
    CAUSE_READA = 3'd3,
    CAUSE_READB = 3'd4,
    CAUSE_MEM   = 3'd5
  } fault_cause_t;

  function automatic logic is_below(input logic [31:0] value, input logic [31:0] limit);
    return value < limit;
  endfunction

  function automatic logic is_above(input logic [31:0] value, input logic [31:0] limit);
    return value > limit;
  endfunction

endpackage

// File: rtl/ring_violation_check.sv
// Combinational user-ring privilege checker.
// Inputs : jump request/target and syscall flag, register write/read selects
//          with their valid bits, data access and address.
// Outputs: violation - any check failed
//          cause     - lowest-numbered failing check (fault_cause_t encoding)
//          addr      - offending jump target, register select or data address
// The caller qualifies the result with the current ring and io_run.
module ring_violation_check
  import ring_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int SEL_W          = 5,
  parameter int RING0_LAST     = 65535,
  parameter int RING0_ENTRY    = 0,
  parameter int PRIV_MEM_WORDS = 0,
  parameter int PRIV_REG_COUNT = 0
) (
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              syscall_pending,
  input  logic              write_enable,
  input  logic [SEL_W-1:0]  write_sel,
  input  logic              read_a_valid,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic              read_b_valid,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic              data_access,
  input  logic [ADDR_W-1:0] data_address,
  output logic              violation,
  output logic [2:0]        cause,
  output logic [ADDR_W-1:0] addr
);

  logic jump_into_kernel;
  logic legal_entry;

  assign jump_into_kernel = jump && !is_above(32'(jump_target), 32'(RING0_LAST));
  assign legal_entry      = (jump_target == ADDR_W'(RING0_ENTRY)) && syscall_pending;

  // If/else order implements the fixed priority: lowest cause number wins.
  always_comb begin
    violation = 1'b0;
    cause     = CAUSE_NONE;
    addr      = '0;
    if (jump_into_kernel && !legal_entry) begin
      violation = 1'b1;
      cause     = CAUSE_JUMP;
      addr      = jump_target;
    end else if (write_enable && is_below(32'(write_sel), 32'(PRIV_REG_COUNT))) begin
      violation = 1'b1;
      cause     = CAUSE_WRITE;
      addr      = ADDR_W'(write_sel);
    end else if (read_a_valid && is_below(32'(a_sel), 32'(PRIV_REG_COUNT))) begin
      violation = 1'b1;
      cause     = CAUSE_READA;
      addr      = ADDR_W'(a_sel);
    end else if (read_b_valid && is_below(32'(b_sel), 32'(PRIV_REG_COUNT))) begin
      violation = 1'b1;
      cause     = CAUSE_READB;
      addr      = ADDR_W'(b_sel);
    end else if (data_access && is_below(32'(data_address), 32'(PRIV_MEM_WORDS))) begin
      violation = 1'b1;
      cause     = CAUSE_MEM;
      addr      = data_address;
    end
  end

endmodule

// File: rtl/ring_controller.sv
// Privilege-ring controller between the core and its program/data memories.
// Inputs : clock, reset (async active-low), io_run, PC, jump/target,
//          syscall flag, data access/address, register read/write selects.
// Outputs: memory offsets, ring flag, syscall ack/return PC/count,
//          sticky fault flag/cause/address, halt request.
//
// state  | meaning
// KERNEL | privileged, no checks, jump above RING0_LAST enters USER
// USER   | unprivileged, every access checked, offsets applied
// ENTRY  | one-cycle syscall entry (ack pulse), then KERNEL
// FAULT  | violation latched, core halted until reset
module ring_controller
  import ring_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int SEL_W          = 5,
  parameter int RING0_LAST     = 65535,
  parameter int RING0_ENTRY    = 0,
  parameter int PRIV_MEM_WORDS = 0,
  parameter int PRIV_REG_COUNT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_run,
  input  logic [ADDR_W-1:0] io_programCounter,
  input  logic              io_jump,
  input  logic [ADDR_W-1:0] io_jumpTarget,
  input  logic              io_syscallPending,
  input  logic              io_dataAccess,
  input  logic [ADDR_W-1:0] io_dataAddress,
  input  logic              io_readAValid,
  input  logic              io_readBValid,
  input  logic [SEL_W-1:0]  io_aSel,
  input  logic [SEL_W-1:0]  io_bSel,
  input  logic              io_writeEnable,
  input  logic [SEL_W-1:0]  io_writeSel,
  output logic [ADDR_W-1:0] io_programMemoryOffset,
  output logic [ADDR_W-1:0] io_dataMemoryOffset,
  output logic              io_privileged,
  output logic              io_syscallAck,
  output logic [ADDR_W-1:0] io_returnPc,
  output logic [15:0]       io_syscallCount,
  output logic              io_fault,
  output logic [2:0]        io_faultCause,
  output logic [ADDR_W-1:0] io_faultAddr,
  output logic              io_halt
);

  // User space starts right after the last kernel address.
  localparam logic [ADDR_W-1:0] USER_OFFSET = ADDR_W'(RING0_LAST + 1);

  ring_state_t       state;
  logic              jump_to_user;
  logic              violation;
  logic [2:0]        chk_cause;
  logic [ADDR_W-1:0] chk_addr;

  assign jump_to_user = io_jump && is_above(32'(io_jumpTarget), 32'(RING0_LAST));

  ring_violation_check #(
    .ADDR_W        (ADDR_W),
    .SEL_W         (SEL_W),
    .RING0_LAST    (RING0_LAST),
    .RING0_ENTRY   (RING0_ENTRY),
    .PRIV_MEM_WORDS(PRIV_MEM_WORDS),
    .PRIV_REG_COUNT(PRIV_REG_COUNT)
  ) u_check (
    .jump           (io_jump),
    .jump_target    (io_jumpTarget),
    .syscall_pending(io_syscallPending),
    .write_enable   (io_writeEnable),
    .write_sel      (io_writeSel),
    .read_a_valid   (io_readAValid),
    .a_sel          (io_aSel),
    .read_b_valid   (io_readBValid),
    .b_sel          (io_bSel),
    .data_access    (io_dataAccess),
    .data_address   (io_dataAddress),
    .violation      (violation),
    .cause          (chk_cause),
    .addr           (chk_addr)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= KERNEL;
      io_returnPc     <= '0;
      io_syscallCount <= '0;
      io_faultCause   <= CAUSE_NONE;
      io_faultAddr    <= '0;
    end else if (io_run) begin
      case (state)
        KERNEL: begin
          if (jump_to_user) state <= USER;
        end
        USER: begin
          if (violation) begin
            state         <= FAULT;
            io_faultCause <= chk_cause;
            io_faultAddr  <= chk_addr;
          end else if (io_jump && !jump_to_user) begin
            // Without a violation, a downward jump can only be the legal syscall entry.
            state           <= ENTRY;
            io_returnPc     <= io_programCounter + ADDR_W'(1);
            io_syscallCount <= io_syscallCount + 16'd1;
          end
        end
        ENTRY: begin
          state <= jump_to_user ? USER : KERNEL;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= KERNEL;
      endcase
    end
  end

  // Moore decode: offsets switch on the edge after the jump, so the first
  // fetch at the new target already sees the new ring's offset.
  assign io_privileged          = (state != USER);
  assign io_programMemoryOffset = (state == USER) ? USER_OFFSET : '0;
  assign io_dataMemoryOffset    = (state == USER) ? USER_OFFSET : '0;
  assign io_syscallAck          = (state == ENTRY);
  assign io_fault               = (state == FAULT);
  assign io_halt                = (state == FAULT);

endmodule

// File: tb/tb_ring_controller.sv
module tb_ring_controller;

  localparam int ADDR_W = 16;
  localparam int SEL_W  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_run;
  logic [ADDR_W-1:0] io_programCounter;
  logic              io_jump;
  logic [ADDR_W-1:0] io_jumpTarget;
  logic              io_syscallPending;
  logic              io_dataAccess;
  logic [ADDR_W-1:0] io_dataAddress;
  logic              io_readAValid;
  logic              io_readBValid;
  logic [SEL_W-1:0]  io_aSel;
  logic [SEL_W-1:0]  io_bSel;
  logic              io_writeEnable;
  logic [SEL_W-1:0]  io_writeSel;
  logic [ADDR_W-1:0] io_programMemoryOffset;
  logic [ADDR_W-1:0] io_dataMemoryOffset;
  logic              io_privileged;
  logic              io_syscallAck;
  logic [ADDR_W-1:0] io_returnPc;
  logic [15:0]       io_syscallCount;
  logic              io_fault;
  logic [2:0]        io_faultCause;
  logic [ADDR_W-1:0] io_faultAddr;
  logic              io_halt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ring_controller #(
    .ADDR_W        (ADDR_W),
    .SEL_W         (SEL_W),
    .RING0_LAST    (16'h0FFF),
    .RING0_ENTRY   (0),
    .PRIV_MEM_WORDS(16'h0100),
    .PRIV_REG_COUNT(4)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_run                (io_run),
    .io_programCounter     (io_programCounter),
    .io_jump               (io_jump),
    .io_jumpTarget         (io_jumpTarget),
    .io_syscallPending     (io_syscallPending),
    .io_dataAccess         (io_dataAccess),
    .io_dataAddress        (io_dataAddress),
    .io_readAValid         (io_readAValid),
    .io_readBValid         (io_readBValid),
    .io_aSel               (io_aSel),
    .io_bSel               (io_bSel),
    .io_writeEnable        (io_writeEnable),
    .io_writeSel           (io_writeSel),
    .io_programMemoryOffset(io_programMemoryOffset),
    .io_dataMemoryOffset   (io_dataMemoryOffset),
    .io_privileged         (io_privileged),
    .io_syscallAck         (io_syscallAck),
    .io_returnPc           (io_returnPc),
    .io_syscallCount       (io_syscallCount),
    .io_fault              (io_fault),
    .io_faultCause         (io_faultCause),
    .io_faultAddr          (io_faultAddr),
    .io_halt               (io_halt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    io_run            = 1'b1;
    io_programCounter = 16'h1000;
    io_jump           = 1'b0;
    io_jumpTarget     = '0;
    io_syscallPending = 1'b0;
    io_dataAccess     = 1'b0;
    io_dataAddress    = '0;
    io_readAValid     = 1'b0;
    io_readBValid     = 1'b0;
    io_aSel           = '0;
    io_bSel           = '0;
    io_writeEnable    = 1'b0;
    io_writeSel       = '0;
  endtask

  // One rising edge; returns at the following falling edge for sampling.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic go_user();
    do_reset();
    io_jump       = 1'b1;
    io_jumpTarget = 16'h1000;
    step();
    idle();
  endtask

  task automatic check_fault(input string tag, input logic [2:0] cause, input logic [15:0] addr);
    check({tag, "_fault"}, 32'(io_fault), 32'd1);
    check({tag, "_halt"},  32'(io_halt), 32'd1);
    check({tag, "_cause"}, 32'(io_faultCause), 32'(cause));
    check({tag, "_addr"},  32'(io_faultAddr), 32'(addr));
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check("rst_priv",   32'(io_privileged), 32'd1);
    check("rst_poff",   32'(io_programMemoryOffset), 32'd0);
    check("rst_doff",   32'(io_dataMemoryOffset), 32'd0);
    check("rst_fault",  32'(io_fault), 32'd0);
    check("rst_halt",   32'(io_halt), 32'd0);
    check("rst_ack",    32'(io_syscallAck), 32'd0);
    check("rst_retpc",  32'(io_returnPc), 32'd0);
    check("rst_count",  32'(io_syscallCount), 32'd0);
    check("rst_cause",  32'(io_faultCause), 32'd0);
    check("rst_faddr",  32'(io_faultAddr), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Kernel: privileged accesses and a jump to the last kernel address are unchecked.
    io_writeEnable = 1'b1; io_writeSel = 5'd0;
    io_dataAccess = 1'b1; io_dataAddress = 16'h0000;
    io_jump = 1'b1; io_jumpTarget = 16'h0FFF;
    step();
    idle();
    check("kern_nofault", 32'(io_fault), 32'd0);
    check("kern_priv",    32'(io_privileged), 32'd1);

    // Kernel to user.
    io_jump = 1'b1; io_jumpTarget = 16'h1000;
    step();
    idle();
    check("k2u_priv", 32'(io_privileged), 32'd0);
    check("k2u_poff", 32'(io_programMemoryOffset), 32'h1000);
    check("k2u_doff", 32'(io_dataMemoryOffset), 32'h1000);

    // User jump upward and boundary-legal accesses: no transition, no fault.
    io_jump = 1'b1; io_jumpTarget = 16'h2000;
    io_readAValid = 1'b1; io_aSel = 5'd4;
    io_dataAccess = 1'b1; io_dataAddress = 16'h0100;
    step();
    idle();
    check("user_ok_priv",  32'(io_privileged), 32'd0);
    check("user_ok_fault", 32'(io_fault), 32'd0);

    // Legal syscall.
    io_programCounter = 16'h1234; io_syscallPending = 1'b1;
    io_jump = 1'b1; io_jumpTarget = 16'h0000;
    step();
    idle();
    check("sys_ack",   32'(io_syscallAck), 32'd1);
    check("sys_retpc", 32'(io_returnPc), 32'h1235);
    check("sys_count", 32'(io_syscallCount), 32'd1);
    check("sys_priv",  32'(io_privileged), 32'd1);
    step();
    check("sys_ack_off", 32'(io_syscallAck), 32'd0);
    check("sys_kpriv",   32'(io_privileged), 32'd1);
    check("sys_kpoff",   32'(io_programMemoryOffset), 32'd0);
    check("sys_kdoff",   32'(io_dataMemoryOffset), 32'd0);

    // Back to user, then syscall from PC 0xFFFF (return PC wraps), then a
    // jump during ENTRY goes straight to USER. io_run=0 in ENTRY holds ENTRY.
    io_jump = 1'b1; io_jumpTarget = 16'h1000;
    step();
    idle();
    io_programCounter = 16'hFFFF; io_syscallPending = 1'b1;
    io_jump = 1'b1; io_jumpTarget = 16'h0000;
    step();
    idle();
    check("wrap_retpc", 32'(io_returnPc), 32'h0000);
    check("wrap_count", 32'(io_syscallCount), 32'd2);
    io_run = 1'b0;
    step();
    check("entry_hold_ack", 32'(io_syscallAck), 32'd1);
    io_run = 1'b1;
    io_jump = 1'b1; io_jumpTarget = 16'h3000;
    step();
    idle();
    check("entry_jump_priv", 32'(io_privileged), 32'd0);
    check("entry_jump_ack",  32'(io_syscallAck), 32'd0);

    // Illegal jump, then 20 cycles of further jumps: fault is sticky.
    io_jump = 1'b1; io_jumpTarget = 16'h0010;
    step();
    check_fault("ill_jump", 3'd1, 16'h0010);
    for (int i = 0; i < 20; i++) begin
      io_jumpTarget = (i % 2 == 0) ? 16'h2000 : 16'h0000;
      io_syscallPending = 1'b1;
      io_writeEnable = 1'b1; io_writeSel = 5'd1;
      step();
    end
    idle();
    check_fault("sticky", 3'd1, 16'h0010);
    check("sticky_priv",  32'(io_privileged), 32'd1);
    check("sticky_count", 32'(io_syscallCount), 32'd2);

    // Asynchronous reset while in FAULT.
    #2 reset = 1'b0;
    #1;
    check("arst_fault", 32'(io_fault), 32'd0);
    check("arst_halt",  32'(io_halt), 32'd0);
    check("arst_cause", 32'(io_faultCause), 32'd0);
    check("arst_faddr", 32'(io_faultAddr), 32'd0);
    check("arst_priv",  32'(io_privileged), 32'd1);
    check("arst_count", 32'(io_syscallCount), 32'd0);
    check("arst_retpc", 32'(io_returnPc), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Jump to entry without a pending syscall.
    go_user();
    io_jump = 1'b1; io_jumpTarget = 16'h0000; io_syscallPending = 1'b0;
    step();
    idle();
    check_fault("nosys", 3'd1, 16'h0000);

    // Simultaneous write r2 and data 0x80: write wins.
    go_user();
    io_writeEnable = 1'b1; io_writeSel = 5'd2;
    io_dataAccess = 1'b1; io_dataAddress = 16'h0080;
    step();
    idle();
    check_fault("simul", 3'd2, 16'h0002);

    // readA r3 and readB r1 together: readA wins.
    go_user();
    io_readAValid = 1'b1; io_aSel = 5'd3;
    io_readBValid = 1'b1; io_bSel = 5'd1;
    step();
    idle();
    check_fault("reada", 3'd3, 16'h0003);

    // readB alone at the boundary select 3.
    go_user();
    io_readBValid = 1'b1; io_bSel = 5'd3;
    io_writeEnable = 1'b1; io_writeSel = 5'd4;
    step();
    idle();
    check_fault("readb", 3'd4, 16'h0003);

    // Data access at the last privileged word.
    go_user();
    io_dataAccess = 1'b1; io_dataAddress = 16'h00FF;
    step();
    idle();
    check_fault("mem", 3'd5, 16'h00FF);

    // Fault beats a legal syscall in the same cycle.
    go_user();
    io_jump = 1'b1; io_jumpTarget = 16'h0000; io_syscallPending = 1'b1;
    io_writeEnable = 1'b1; io_writeSel = 5'd1;
    step();
    idle();
    check_fault("prio", 3'd1 + 3'd1, 16'h0001);
    check("prio_count", 32'(io_syscallCount), 32'd0);
    check("prio_ack",   32'(io_syscallAck), 32'd0);

    // Run gating: an illegal jump with io_run=0 does nothing.
    go_user();
    io_run = 1'b0;
    io_jump = 1'b1; io_jumpTarget = 16'h0010;
    step();
    step();
    idle();
    check("gate_fault", 32'(io_fault), 32'd0);
    check("gate_priv",  32'(io_privileged), 32'd0);
    step();
    check("gate_after", 32'(io_fault), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
